// File: rtl/error_injector_seq.sv
// error_injector_seq: sequential bit-flip error injector placed between the
// ECC encoder and decoder. Buttons are synchronised, debounced and
// edge-detected, each one mapped to data bit i*STRIDE. Corruption is applied
// in off / level / one-shot / burst modes and corrupted words are counted.
// Optional build macro ERR_INJ_RANDOM_EN adds a rand_en port and an LFSR
// that sprinkles additional single-bit flips into the stream.
module error_injector_seq #(
  parameter int DATA_W    = 8,
  parameter int NUM_BTN   = 2,
  parameter int STRIDE    = 4,
  parameter int DB_CYCLES = 16,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [1:0]        mode,
`ifdef ERR_INJ_RANDOM_EN
  input  logic              rand_en,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              injected,
  output logic [CNT_W-1:0]  err_count
);

  localparam int DB_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam int BC_W = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2
  } state_t;

  // Place one bit per button at its target data position.
  function automatic logic [DATA_W-1:0] map_btn(input logic [NUM_BTN-1:0] b);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_BTN; i++) m[i*STRIDE] = b[i];
    return m;
  endfunction

  // Counter increment that sticks at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [NUM_BTN-1:0]           btn_sync_p0, btn_sync_p1;
  logic [NUM_BTN-1:0]           db_state;
  logic [NUM_BTN-1:0]           press_p;
  logic [NUM_BTN-1:0][DB_W-1:0] db_cnt;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pending_mask, pending_nxt;
  logic [DATA_W-1:0] burst_mask, burst_nxt;
  logic [BC_W-1:0]   burst_cnt, cnt_nxt;
  logic [DATA_W-1:0] press_mask;
  logic [DATA_W-1:0] btn_mask;
  logic [DATA_W-1:0] applied_mask;

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
    end else begin
      btn_sync_p0 <= btn;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // Debounce: accept a change after DB_CYCLES consecutive differing cycles;
  // a debounced rising edge emits a one-cycle press pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_state <= '0;
      press_p  <= '0;
      db_cnt   <= '0;
    end else begin
      press_p <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync_p1[i] != db_state[i]) begin
          if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
            db_state[i] <= btn_sync_p1[i];
            press_p[i]  <= btn_sync_p1[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press_mask = map_btn(press_p);

  // Injection FSM state and mask registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      pending_mask <= '0;
      burst_mask   <= '0;
      burst_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      pending_mask <= pending_nxt;
      burst_mask   <= burst_nxt;
      burst_cnt    <= cnt_nxt;
    end
  end

  // Next-state and button-derived mask; presses landing in the consuming
  // cycle are carried into the next pending mask rather than merged.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_mask | press_mask;
    burst_nxt   = burst_mask;
    cnt_nxt     = burst_cnt;
    btn_mask    = '0;
    case (mode)
      2'b00: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        burst_nxt   = '0;
        cnt_nxt     = '0;
      end
      2'b01: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        burst_nxt   = '0;
        cnt_nxt     = '0;
        btn_mask    = map_btn(db_state);
      end
      default: begin
        case (state)
          IDLE: begin
            if (pending_mask != '0) state_nxt = ARMED;
          end
          ARMED: begin
            if (valid_in) begin
              btn_mask    = pending_mask;
              pending_nxt = press_mask;
              if (mode == 2'b11 && BURST_LEN > 1) begin
                burst_nxt = pending_mask;
                cnt_nxt   = BC_W'(BURST_LEN - 1);
                state_nxt = BURST;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
          BURST: begin
            if (valid_in) begin
              btn_mask = burst_mask;
              cnt_nxt  = burst_cnt - 1'b1;
              if (burst_cnt == BC_W'(1)) begin
                burst_nxt = '0;
                state_nxt = IDLE;
              end
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    endcase
  end

`ifdef ERR_INJ_RANDOM_EN
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] rand_mask;

  // Fibonacci LFSR, taps 16,14,13,11, stepped once per valid word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= 16'hACE1;
    end else if (valid_in) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Occasional random bit flip; XOR lets it cancel a coinciding button bit.
  always_comb begin
    rand_mask = '0;
    if (rand_en && (mode != 2'b00) && (lfsr[3:0] == 4'd0))
      rand_mask[32'(lfsr[15:8]) % DATA_W] = 1'b1;
    applied_mask = btn_mask ^ rand_mask;
  end
`else
  // Without the random source the button mask is applied unchanged.
  always_comb begin
    applied_mask = btn_mask;
  end
`endif

  // Output register: one-cycle latency, data holds on idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      injected  <= 1'b0;
      err_count <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= data_in ^ applied_mask;
        injected <= (applied_mask != '0);
        if (applied_mask != '0) err_count <= sat_inc(err_count);
      end else begin
        injected <= 1'b0;
      end
    end
  end

endmodule
